// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg -- shared definitions for the multicycle RISC-V control path.
// Holds the main FSM state encoding, the opcode constants it decodes, the
// datapath mux/ALU-class encodings and the packed control-word layout used
// between the FSM top and its output decoder.
package riscv_mc_pkg;

  // Main controller states; values are visible on the debug state output.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  // Opcodes recognised by the decoder.
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALU A operand select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU decoder class.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // One control word per cycle; the top gates the enables with reset.
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // DECODE dispatch: maps an opcode to the first execution state.
  // Unknown opcodes go to TRAP.
  function automatic state_e decode_target(input logic [6:0] op);
    state_e tgt;
    case (op)
      OP_LW, OP_SW: tgt = S_MEMADR;
      OP_R:         tgt = S_EXECR;
      OP_I:         tgt = S_EXECI;
      OP_JAL:       tgt = S_JAL;
      OP_BEQ:       tgt = S_BEQ;
      default:      tgt = S_TRAP;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/main_fsm_if.sv
// main_fsm_if -- bundle between the main controller and the datapath.
// Signals:
//   op, memReady            datapath -> FSM (instruction opcode, memory done)
//   pcUpdate, branch,
//   regWrite, memWrite,
//   irWrite                 FSM -> datapath write enables
//   adrSrc, aluSrcA/B,
//   resultSrc, aluOp        FSM -> datapath mux and ALU-class selects
//   illegal, state          FSM -> observers (trap flag, debug state)
// Modports: slave = the FSM, master = the datapath / environment.
interface main_fsm_if;
  logic [6:0] op;
  logic       memReady;
  logic       pcUpdate;
  logic       branch;
  logic       regWrite;
  logic       memWrite;
  logic       irWrite;
  logic       adrSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] resultSrc;
  logic [1:0] aluOp;
  logic       illegal;
  logic [3:0] state;

  modport slave (
    input  op, memReady,
    output pcUpdate, branch, regWrite, memWrite, irWrite,
    output adrSrc, aluSrcA, aluSrcB, resultSrc, aluOp,
    output illegal, state
  );

  modport master (
    output op, memReady,
    input  pcUpdate, branch, regWrite, memWrite, irWrite,
    input  adrSrc, aluSrcA, aluSrcB, resultSrc, aluOp,
    input  illegal, state
  );
endinterface

// File: rtl/main_fsm_outdec.sv
// main_fsm_outdec -- output decoder for the main controller.
// Ports:
//   state_i      current FSM state
//   mem_ready_i  memory handshake (used only by the FETCH Mealy terms)
//   ctrl_o       decoded control word, not yet gated by reset
module main_fsm_outdec
  import riscv_mc_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.adr_src    = 1'b0;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.result_src = RES_ALURESULT;
        // Latch the instruction and advance PC only once memory delivers.
        ctrl_o.ir_write   = mem_ready_i;
        ctrl_o.pc_update  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.mem_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_RS2;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl_o.alu_src_a = SRCA_RS1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
      end
      S_JAL: begin
        ctrl_o.alu_src_a  = SRCA_OLDPC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_update  = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a  = SRCA_RS1;
        ctrl_o.alu_src_b  = SRCB_RS2;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.branch     = 1'b1;
      end
      S_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// main_fsm -- main controller of the multicycle RISC-V core.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; also masks all write enables while high
//   bus    main_fsm_if.slave: op/memReady in; enables, selects, illegal and
//          debug state out
// The state register is the only storage; next-state and output decoding are
// separate combinational processes (the latter in main_fsm_outdec).
module main_fsm
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.slave  bus
);

  state_e state_q;
  state_e state_d;
  ctrl_t  raw_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = decode_target(bus.op);
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = bus.memReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = bus.memReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;   // only reset leaves TRAP
      // Unused encodings cannot be reached; treat them as a fault.
      default:    state_d = S_TRAP;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (bus.memReady),
    .ctrl_o      (raw_ctrl)
  );

  // Enables are masked by reset combinationally so an instruction interrupted
  // mid-flight cannot write anything in the reset cycle. Selects and the
  // illegal flag keep following the current state.
  assign bus.pcUpdate  = raw_ctrl.pc_update & ~reset;
  assign bus.branch    = raw_ctrl.branch    & ~reset;
  assign bus.regWrite  = raw_ctrl.reg_write & ~reset;
  assign bus.memWrite  = raw_ctrl.mem_write & ~reset;
  assign bus.irWrite   = raw_ctrl.ir_write  & ~reset;
  assign bus.adrSrc    = raw_ctrl.adr_src;
  assign bus.aluSrcA   = raw_ctrl.alu_src_a;
  assign bus.aluSrcB   = raw_ctrl.alu_src_b;
  assign bus.resultSrc = raw_ctrl.result_src;
  assign bus.aluOp     = raw_ctrl.alu_op;
  assign bus.illegal   = raw_ctrl.illegal;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm -- directed and randomized bench for main_fsm.
// The reference model expands each instruction into the list of states it
// must visit (from the opcode class and the memory wait counts) and looks up
// the required control outputs for each state from a table of the state
// output assignments. Outputs are compared mid-cycle, away from clock edges.
module tb_main_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cyc;

  main_fsm_if bus ();

  main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // Control word {pcUpdate, branch, regWrite, memWrite, irWrite, adrSrc,
  //               aluSrcA, aluSrcB, resultSrc, aluOp, illegal}
  function automatic logic [14:0] exp_ctrl(input int st, input logic mr, input logic rst);
    logic [14:0] v;
    case (st)
      0:  v = {mr,   1'b0, 1'b0, 1'b0, mr,   1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
      1:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
      2:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
      3:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4:  v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
      5:  v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      6:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
      7:  v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      8:  v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0};
      9:  v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
      10: v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0};
      15: v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
      default: v = '0;
    endcase
    if (rst) v[14:10] = 5'b0;
    return v;
  endfunction

  // One clock cycle: apply inputs, check mid-cycle, advance past the edge.
  task automatic do_cycle(input int exp_st, input logic mr, input logic rst);
    logic [14:0] e;
    logic [14:0] o;
    bus.memReady = mr;
    reset        = rst;
    #4;
    e = exp_ctrl(exp_st, mr, rst);
    o = {bus.pcUpdate, bus.branch, bus.regWrite, bus.memWrite, bus.irWrite,
         bus.adrSrc, bus.aluSrcA, bus.aluSrcB, bus.resultSrc, bus.aluOp, bus.illegal};
    tests++;
    assert (bus.state === 4'(exp_st)) else begin
      fails++;
      $error("FAIL state cyc=%0d op=%b got %0d exp %0d", cyc, bus.op, bus.state, exp_st);
    end
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL ctrl cyc=%0d state=%0d mr=%b rst=%b got %b exp %b",
             cyc, exp_st, mr, rst, o, e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expand one instruction into its expected state walk and run it.
  // fw = FETCH wait cycles, rw = MEMREAD/MEMWRITE wait cycles.
  task automatic run_instr(input logic [6:0] opc, input int fw, input int rw);
    int   sq[$];
    logic mq[$];
    bus.op = opc;
    for (int i = 0; i < fw; i++) begin sq.push_back(0); mq.push_back(1'b0); end
    sq.push_back(0); mq.push_back(1'b1);
    sq.push_back(1); mq.push_back(1'($urandom));
    case (opc)
      LW: begin
        sq.push_back(2); mq.push_back(1'($urandom));
        for (int i = 0; i < rw; i++) begin sq.push_back(3); mq.push_back(1'b0); end
        sq.push_back(3); mq.push_back(1'b1);
        sq.push_back(4); mq.push_back(1'($urandom));
      end
      SW: begin
        sq.push_back(2); mq.push_back(1'($urandom));
        for (int i = 0; i < rw; i++) begin sq.push_back(5); mq.push_back(1'b0); end
        sq.push_back(5); mq.push_back(1'b1);
      end
      RT: begin
        sq.push_back(6); mq.push_back(1'($urandom));
        sq.push_back(7); mq.push_back(1'($urandom));
      end
      IT: begin
        sq.push_back(8); mq.push_back(1'($urandom));
        sq.push_back(7); mq.push_back(1'($urandom));
      end
      JL: begin
        sq.push_back(9); mq.push_back(1'($urandom));
        sq.push_back(7); mq.push_back(1'($urandom));
      end
      BQ: begin
        sq.push_back(10); mq.push_back(1'($urandom));
      end
      default: begin
        sq.push_back(15); mq.push_back(1'($urandom));
      end
    endcase
    foreach (sq[i]) do_cycle(sq[i], mq[i], 1'b0);
  endtask

  function automatic logic is_legal(input logic [6:0] opc);
    return (opc == LW) || (opc == SW) || (opc == RT) || (opc == IT) ||
           (opc == JL) || (opc == BQ);
  endfunction

  initial begin
    logic [6:0] rop;
    tests = 0;
    fails = 0;
    cyc   = 0;
    reset = 1'b1;
    bus.op       = 7'd0;
    bus.memReady = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: FETCH, enables masked even with memReady high.
    do_cycle(0, 1'b1, 1'b1);
    // Released: FETCH values, enables low while memory is not ready.
    do_cycle(0, 1'b0, 1'b0);

    // lw with memory always ready: 0,1,2,3,4 then FETCH.
    run_instr(LW, 0, 0);
    // sw held three extra cycles in MEMWRITE.
    run_instr(SW, 0, 3);
    // FETCH stalls two cycles before the R-type proceeds.
    run_instr(RT, 2, 0);
    run_instr(BQ, 0, 0);
    run_instr(JL, 0, 0);
    run_instr(IT, 1, 0);
    run_instr(LW, 0, 2);

    // Illegal opcode: TRAP for 20 cycles, reset keeps illegal visible, then FETCH.
    run_instr(BAD, 0, 0);
    for (int i = 0; i < 19; i++) do_cycle(15, 1'($urandom), 1'b0);
    do_cycle(15, 1'b1, 1'b1);
    do_cycle(0, 1'b0, 1'b0);

    // Reset in the middle of a store.
    bus.op = SW;
    do_cycle(0, 1'b1, 1'b0);
    do_cycle(1, 1'b0, 1'b0);
    do_cycle(2, 1'b0, 1'b0);
    do_cycle(5, 1'b0, 1'b0);
    do_cycle(5, 1'b0, 1'b1);
    do_cycle(0, 1'b0, 1'b0);

    // Randomized instruction mix with random memory latencies.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = IT;
        4: rop = JL;
        5: rop = BQ;
        default: rop = 7'($urandom);
      endcase
      run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3));
      if (!is_legal(rop)) begin
        for (int i = 0; i < $urandom_range(0, 4); i++) do_cycle(15, 1'($urandom), 1'b0);
        do_cycle(15, 1'($urandom), 1'b1);
      end
    end
    do_cycle(0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port op, input, 7 bits: opcode of the instruction register.
REQ-004 SHALL have port memReady, input, 1 bit: memory completed the current access this cycle.
REQ-005 SHALL have port pcUpdate, output, 1 bit: PC register write enable.
REQ-006 SHALL have port branch, output, 1 bit: conditional PC write, qualified by zero outside this block.
REQ-007 SHALL have ports regWrite, memWrite and irWrite, output, 1 bit each: register file, data memory and instruction register write enables.
REQ-008 SHALL have port adrSrc, output, 1 bit: memory address select, 0=PC, 1=Result.
REQ-009 SHALL have port aluSrcA, output, 2 bits: ALU A select, 00=PC, 01=OldPC, 10=rs1 data.
REQ-010 SHALL have port aluSrcB, output, 2 bits: ALU B select, 00=rs2 data, 01=ImmExt, 10=constant 4.
REQ-011 SHALL have port resultSrc, output, 2 bits: result select, 00=ALUOut, 01=Data, 10=ALUResult.
REQ-012 SHALL have port aluOp, output, 2 bits: ALU decoder class, 00=add, 01=sub/compare, 10=funct-decoded.
REQ-013 SHALL have port illegal, output, 1 bit: sticky flag, asserted while in TRAP.
REQ-014 SHALL have port state, output, 4 bits: current state encoding, for debug.

Function
REQ-015 SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, TRAP=15.
REQ-016 Any output not listed for a state SHALL be 0.
REQ-017 FETCH SHALL drive adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10.
REQ-018 In FETCH, irWrite and pcUpdate SHALL be 1 only when memReady=1 (the only Mealy terms).
REQ-019 FETCH SHALL go to DECODE when memReady=1; otherwise it SHALL stay in FETCH.
REQ-020 DECODE SHALL drive aluSrcA=01, aluSrcB=01, aluOp=00.
REQ-021 DECODE SHALL branch on op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ; any other value -> TRAP.
REQ-022 MEMADR SHALL drive aluSrcA=10, aluSrcB=01, aluOp=00, then go to MEMREAD if op=0000011, else MEMWRITE.
REQ-023 MEMREAD SHALL drive adrSrc=1, resultSrc=00; it SHALL go to MEMWB when memReady=1, else hold.
REQ-024 MEMWB SHALL drive resultSrc=01, regWrite=1, then go to FETCH.
REQ-025 MEMWRITE SHALL drive adrSrc=1, resultSrc=00, memWrite=1 for every cycle held; it SHALL go to FETCH when memReady=1, else hold.
REQ-026 EXECR SHALL drive aluSrcA=10, aluSrcB=00, aluOp=10, then go to ALUWB.
REQ-027 EXECI SHALL drive aluSrcA=10, aluSrcB=01, aluOp=10, then go to ALUWB.
REQ-028 ALUWB SHALL drive resultSrc=00, regWrite=1, then go to FETCH.
REQ-029 JAL SHALL drive aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1, then go to ALUWB.
REQ-030 BEQ SHALL drive aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1, then go to FETCH.
REQ-031 TRAP SHALL drive illegal=1, hold all enables at 0, and be left only by reset.
REQ-032 memReady SHALL be ignored in states not listed as waiting (FETCH, MEMREAD, MEMWRITE).
REQ-033 Instruction latency with memReady always 1 SHALL be: lw 5 cycles, sw 4, R/I-type 4, jal 4, beq 3.

Reset
REQ-034 When reset=1 at a rising edge, state SHALL become FETCH.
REQ-035 While reset=1, pcUpdate, branch, regWrite, memWrite and irWrite SHALL be forced to 0 combinationally, including when reset is asserted mid-instruction; this SHALL apply in every state.
REQ-036 While reset=1, illegal SHALL remain driven from the current state.
REQ-037 Immediately after reset, outputs SHALL equal the FETCH values: all enables 0 until memReady=1, and illegal=0.

Structure
REQ-038 The state encodings, opcode constants and the aluSrcA/aluSrcB/resultSrc/aluOp encodings SHALL live in the shared package riscv_mc_pkg.
REQ-039 The state register SHALL be the only storage element.
REQ-040 Next-state logic and output logic SHALL be separate combinational processes.
REQ-041 Output decoding MAY be one sub-module, main_fsm_outdec: state and memReady in, controls out.

Verification
REQ-042 Reset, then lw (op=0000011) with memReady=1 SHALL produce states 0,1,2,3,4,0, with regWrite=1 only in cycle 5 and resultSrc=01.
REQ-043 sw with memReady low for 3 cycles in MEMWRITE SHALL keep memWrite=1 for 4 cycles, then return to FETCH with memWrite=0.
REQ-044 FETCH with memReady=0 for 2 cycles SHALL keep irWrite=0 and pcUpdate=0 and state=0; on the third cycle, with memReady=1, irWrite=1 and pcUpdate=1.
REQ-045 beq SHALL produce states 0,1,10, with branch=1 and aluOp=01 in state 10; jal SHALL produce 0,1,9,7, with pcUpdate=1 in state 9.
REQ-046 op=1111111 SHALL give DECODE -> TRAP with illegal=1 held for 20 cycles; reset SHALL then return to FETCH with illegal=0.
REQ-047 Reset asserted during MEMWRITE SHALL force memWrite=0 in that same cycle and give state=0 on the next cycle.
